pe_array_sequencer: RTL and testbench

Initiator/controller for the halved, pipelined processing-element chain of the Pair-HMM systolic array. It accepts one read/haplotype job and walks the anti-diagonal wavefront across NUM_PE PEs. For each wavefront step it drives the per-PE enable and set_tb_special lines, waits until every enabled PE reports done, then issues the shared advance pulse. It also forwards downstream back-pressure as global_stall, and flags when the last active PE's registered output holds a valid column result for the result collector.

---
 rtl/pe_array_sequencer_if.sv | 37 +++
 rtl/pe_array_sequencer.sv | 135 +++++++++++++
 tb/tb_pe_array_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_sequencer_if.sv
// Job, PE-chain and result-collector signals of the Pair-HMM wavefront sequencer.
// master = sequencer side, slave = job source / PE chain / collector side.
interface pe_array_sequencer_if #(
  parameter int NUM_PE = 4,
  parameter int LEN_W  = 16,
  parameter int TAG_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  read_len;
  logic [LEN_W-1:0]  hap_len;
  logic [TAG_W-1:0]  tag_in;
  logic [NUM_PE-1:0] pe_done;
  logic [NUM_PE-1:0] pe_stall;
  logic              downstream_stall;
  logic              advance;
  logic [NUM_PE-1:0] pe_enable;
  logic [NUM_PE-1:0] set_tb_special;
  logic              global_stall;
  logic              busy;
  logic              col_valid;
  logic [LEN_W-1:0]  col_idx;
  logic              finished;
  logic              err;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    input  start, read_len, hap_len, tag_in, pe_done, pe_stall, downstream_stall,
    output advance, pe_enable, set_tb_special, global_stall, busy,
           col_valid, col_idx, finished, err, tag_out
  );

  modport slave (
    output start, read_len, hap_len, tag_in, pe_done, pe_stall, downstream_stall,
    input  advance, pe_enable, set_tb_special, global_stall, busy,
           col_valid, col_idx, finished, err, tag_out
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Walks the anti-diagonal wavefront of one read/haplotype job across the PE chain,
// issuing one shared advance per step once every enabled PE has reported done.
module pe_array_sequencer #(
  parameter int NUM_PE = 4,
  parameter int LEN_W  = 16,
  parameter int TAG_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pe_array_sequencer_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | enables held for step s, waiting for all enabled dones
  // ADV   | advance pulse, enables still hold step s
  // FIN   | one-cycle finished (err set when the job was rejected)
  typedef enum logic [1:0] {IDLE, RUN, ADV, FIN} state_t;

  localparam int SW = LEN_W + 1;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  r_q, r_d, h_q, h_d;
  logic [SW-1:0]     s_q, s_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              busy_q, busy_d, adv_q, adv_d, gstall_q, gstall_d;
  logic              col_valid_q, col_valid_d, fin_q, fin_d, err_q, err_d;
  logic [LEN_W-1:0]  col_idx_q, col_idx_d;
  logic [NUM_PE-1:0] en_q, en_d, tbs_q, tbs_d;

  logic              job_bad, all_done, last_en;
  logic [SW-1:0]     steps, s_inc, col_diff, pe_idx;

  assign job_bad  = (bus.read_len == '0) || (bus.hap_len == '0) ||
                    (bus.read_len > LEN_W'(NUM_PE));
  assign all_done = ((bus.pe_done & en_q) == en_q);
  // Step count kept one bit wider so R+H-1 cannot wrap.
  assign steps    = {1'b0, r_q} + {1'b0, h_q} - SW'(1);
  assign s_inc    = s_q + SW'(1);
  assign col_diff = s_q - {1'b0, r_q} + SW'(1);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    h_d     = h_q;
    s_d     = s_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        if (job_bad) begin
          state_d = FIN;
        end else begin
          r_d     = bus.read_len;
          h_d     = bus.hap_len;
          tag_d   = bus.tag_in;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN:  if (all_done && !bus.downstream_stall) state_d = ADV;
      ADV: begin
        s_d     = s_inc;
        state_d = (s_inc == steps) ? FIN : RUN;
      end
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d == RUN) || (state_d == ADV);
    adv_d    = (state_d == ADV);
    fin_d    = (state_d == FIN);
    err_d    = (state_q == IDLE) && bus.start && job_bad;
    gstall_d = bus.downstream_stall;
    last_en  = 1'b0;
    pe_idx   = '0;
    en_d     = '0;
    tbs_d    = '0;
    // Enables are computed from next-cycle state so they are valid on entry to RUN.
    for (int i = 0; i < NUM_PE; i++) begin
      pe_idx   = SW'(i);
      en_d[i]  = busy_d && (pe_idx < {1'b0, r_d}) && (pe_idx <= s_d) &&
                 ((s_d - pe_idx) < {1'b0, h_d});
      tbs_d[i] = en_d[i] && (s_d == pe_idx);
      if (SW'(i + 1) == {1'b0, r_q}) last_en = en_q[i];
    end
    col_valid_d = (state_q == ADV) && last_en;
    col_idx_d   = col_valid_d ? col_diff[LEN_W-1:0] : col_idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      h_q         <= '0;
      s_q         <= '0;
      tag_q       <= '0;
      busy_q      <= 1'b0;
      adv_q       <= 1'b0;
      gstall_q    <= 1'b0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
      en_q        <= '0;
      tbs_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      h_q         <= h_d;
      s_q         <= s_d;
      tag_q       <= tag_d;
      busy_q      <= busy_d;
      adv_q       <= adv_d;
      gstall_q    <= gstall_d;
      col_valid_q <= col_valid_d;
      col_idx_q   <= col_idx_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
      en_q        <= en_d;
      tbs_q       <= tbs_d;
    end
  end

  assign bus.advance        = adv_q;
  assign bus.pe_enable      = en_q;
  assign bus.set_tb_special = tbs_q;
  assign bus.global_stall   = gstall_q;
  assign bus.busy           = busy_q;
  assign bus.col_valid      = col_valid_q;
  assign bus.col_idx        = col_idx_q;
  assign bus.finished       = fin_q;
  assign bus.err            = err_q;
  assign bus.tag_out        = tag_q;
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer: stub PEs, scoreboard of expected advances,
// column results and end-of-job pulses.
module tb_pe_array_sequencer;
  localparam int NUM_PE = 4;
  localparam int LEN_W  = 16;
  localparam int TAG_W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pe_array_sequencer_if #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .TAG_W(TAG_W)) bus ();
  pe_array_sequencer #(.NUM_PE(NUM_PE), .LEN_W(LEN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_PE-1:0] en;
    logic [NUM_PE-1:0] tbs;
  } adv_exp_t;

  adv_exp_t         exp_adv[$];
  logic [LEN_W-1:0] exp_col[$];
  logic             exp_err[$];

  int tests = 0, fails = 0;
  int adv_seen = 0, col_seen = 0, fin_seen = 0, cyc = 0;
  int pe_delay[NUM_PE];
  int pe_cnt[NUM_PE];
  logic [NUM_PE-1:0] force_done = '0;
  logic prev_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] outs();
    return {26'b0, bus.advance, bus.pe_enable, bus.set_tb_special, bus.global_stall,
            bus.busy, bus.col_valid, bus.col_idx, bus.finished, bus.err, bus.tag_out};
  endfunction

  // Expected wavefront derived from the job geometry: PE i works column s-i of row i.
  task automatic push_job(input int r, input int h);
    adv_exp_t e;
    for (int s = 0; s < r + h - 1; s++) begin
      e = '0;
      for (int i = 0; i < NUM_PE; i++) begin
        if (i < r && i <= s && (s - i) < h) e.en[i] = 1'b1;
        if (e.en[i] && s == i) e.tbs[i] = 1'b1;
      end
      exp_adv.push_back(e);
    end
    for (int c = 0; c < h; c++) exp_col.push_back(LEN_W'(c));
    exp_err.push_back(1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_job(input int r, input int h, input logic [TAG_W-1:0] tag);
    tick();
    bus.start    = 1'b1;
    bus.read_len = LEN_W'(r);
    bus.hap_len  = LEN_W'(h);
    bus.tag_in   = tag;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_fin(input int target, input string tag);
    for (int k = 0; k < 400 && fin_seen < target; k++) tick();
    chk({tag, "_finish_seen"}, fin_seen >= target, 1'b1);
    tick();
    chk({tag, "_adv_left"}, exp_adv.size(), 0);
    chk({tag, "_col_left"}, exp_col.size(), 0);
  endtask

  // Stub PEs: done once enabled for pe_delay cycles; counts clear on advance.
  initial begin
    bus.pe_done = '0;
    for (int i = 0; i < NUM_PE; i++) pe_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_PE; i++) begin
        if (reset || bus.advance) pe_cnt[i] = 0;
        else if (bus.pe_enable[i] && pe_cnt[i] < 1000) pe_cnt[i]++;
        bus.pe_done[i] = (bus.pe_enable[i] && pe_cnt[i] >= pe_delay[i]) || force_done[i];
      end
    end
  end

  // Output monitor / scoreboard consumer.
  initial begin
    adv_exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset) begin
        if (bus.advance) begin
          adv_seen++;
          chk("adv_after_all_done", prev_ok, 1'b1);
          chk("adv_expected", exp_adv.size() != 0, 1'b1);
          if (exp_adv.size() != 0) begin
            e = exp_adv.pop_front();
            chk("adv_pe_enable", bus.pe_enable, e.en);
            chk("adv_set_tb_special", bus.set_tb_special, e.tbs);
          end
        end
        if (bus.col_valid) begin
          col_seen++;
          chk("col_expected", exp_col.size() != 0, 1'b1);
          if (exp_col.size() != 0) chk("col_idx", bus.col_idx, exp_col.pop_front());
        end
        if (bus.finished) begin
          fin_seen++;
          chk("fin_expected", exp_err.size() != 0, 1'b1);
          if (exp_err.size() != 0) chk("fin_err", bus.err, exp_err.pop_front());
        end
      end
      prev_ok = ((bus.pe_done & bus.pe_enable) == bus.pe_enable) && !bus.downstream_stall
                && bus.busy && !bus.advance;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, f0, c0, t0, t1, n;
    bus.start = 1'b0; bus.read_len = '0; bus.hap_len = '0; bus.tag_in = '0;
    bus.pe_stall = '0; bus.downstream_stall = 1'b0;
    for (int i = 0; i < NUM_PE; i++) pe_delay[i] = 2;
    repeat (3) tick();
    chk("reset_outputs", outs(), 64'd0);
    reset = 1'b0;

    // R=2,H=3: fixed expected wavefront.
    exp_adv.push_back({4'b0001, 4'b0001});
    exp_adv.push_back({4'b0011, 4'b0010});
    exp_adv.push_back({4'b0011, 4'b0000});
    exp_adv.push_back({4'b0010, 4'b0000});
    exp_col.push_back(16'd0); exp_col.push_back(16'd1); exp_col.push_back(16'd2);
    exp_err.push_back(1'b0);
    a0 = adv_seen; c0 = col_seen;
    start_job(2, 3, 8'h11);
    #3 chk("r2h3_busy_on_entry", bus.busy, 1'b1);
    chk("r2h3_first_enable", bus.pe_enable, 4'b0001);
    wait_fin(1, "r2h3");
    chk("r2h3_adv_count", adv_seen - a0, 4);
    chk("r2h3_col_count", col_seen - c0, 3);
    chk("r2h3_tag_out", bus.tag_out, 8'h11);
    chk("r2h3_idle_outputs", {bus.busy, bus.pe_enable, bus.finished}, 6'd0);

    // Rejected jobs: R>NUM_PE, R=0, H=0.
    for (int k = 0; k < 3; k++) begin
      int rr, hh;
      rr = (k == 0) ? 5 : (k == 1) ? 0 : 2;
      hh = (k == 0) ? 2 : (k == 1) ? 3 : 0;
      exp_err.push_back(1'b1);
      a0 = adv_seen;
      start_job(rr, hh, 8'hE0);
      #3 chk($sformatf("reject%0d_fin_err", k), {bus.finished, bus.err}, 2'b11);
      chk($sformatf("reject%0d_quiet", k), {bus.pe_enable, bus.advance, bus.busy}, 6'd0);
      tick();
      #3 chk($sformatf("reject%0d_fin_once", k), bus.finished, 1'b0);
      chk($sformatf("reject%0d_no_adv", k), adv_seen - a0, 0);
      chk($sformatf("reject%0d_tag_kept", k), bus.tag_out, 8'h11);
    end

    // Downstream stall holds off advance; global_stall lags by a cycle.
    tick();
    bus.downstream_stall = 1'b1;
    #1 chk("gstall_lag_rise", bus.global_stall, 1'b0);
    tick();
    chk("gstall_follow_rise", bus.global_stall, 1'b1);
    push_job(1, 1);
    a0 = adv_seen;
    start_job(1, 1, 8'h22);
    for (int k = 0; k < 20 && !bus.pe_done[0]; k++) tick();
    chk("stall_done_seen", bus.pe_done[0], 1'b1);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.advance) n++;
    end
    chk("stall_no_adv", n, 0);
    chk("stall_busy", bus.busy, 1'b1);
    bus.downstream_stall = 1'b0;
    #1 chk("gstall_lag_fall", bus.global_stall, 1'b1);
    tick();
    chk("stall_adv_after_drop", bus.advance, 1'b1);
    chk("gstall_follow_fall", bus.global_stall, 1'b0);
    wait_fin(fin_seen + 1, "stall");
    chk("stall_adv_count", adv_seen - a0, 1);

    // Reset in the middle of a job, then a normal job.
    push_job(3, 3);
    a0 = adv_seen; f0 = fin_seen;
    start_job(3, 3, 8'h33);
    for (int k = 0; k < 100 && adv_seen < a0 + 2; k++) tick();
    chk("midreset_reached_s2", adv_seen - a0, 2);
    tick();
    exp_adv.delete(); exp_col.delete(); exp_err.delete();
    reset = 1'b1;
    tick();
    chk("midreset_outputs", outs(), 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("midreset_no_finish", fin_seen, f0);
    push_job(1, 2);
    a0 = adv_seen;
    start_job(1, 2, 8'h44);
    wait_fin(f0 + 1, "after_reset");
    chk("after_reset_adv_count", adv_seen - a0, 2);

    // start while busy is ignored.
    push_job(3, 2);
    a0 = adv_seen;
    start_job(3, 2, 8'h55);
    tick(); tick();
    bus.start = 1'b1; bus.read_len = 16'd1; bus.hap_len = 16'd1; bus.tag_in = 8'hAA;
    tick();
    bus.start = 1'b0;
    wait_fin(fin_seen + 1, "busy_start");
    chk("busy_start_tag", bus.tag_out, 8'h55);
    chk("busy_start_adv_count", adv_seen - a0, 4);

    // Done on a disabled PE alone never advances; slow PE1 holds the step.
    pe_delay[0] = 200;
    force_done = 4'b0010;
    push_job(2, 2);
    a0 = adv_seen;
    start_job(2, 2, 8'h66);
    repeat (8) tick();
    chk("disabled_done_no_adv", adv_seen - a0, 0);
    pe_delay[0] = 2;
    pe_delay[1] = 7;
    force_done = '0;
    for (int k = 0; k < 50 && adv_seen < a0 + 1; k++) tick();
    t0 = cyc;
    for (int k = 0; k < 50 && adv_seen < a0 + 2; k++) tick();
    t1 = cyc;
    chk("slow_pe1_step_gap", t1 - t0, 8);
    wait_fin(fin_seen + 1, "slow_pe1");
    chk("slow_pe1_adv_count", adv_seen - a0, 3);
    pe_delay[1] = 2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
